coef_access_ctrl: RTL and testbench
===================================

# coef_access_ctrl

Parametrised coefficient-RAM access controller for the FIR datapath. It arbitrates `NUM_BANK` coefficient RAM banks between the host bus (coefficient update) and an internal per-sample read sequencer. Mode switches are handshaked and only happen on sample-frame boundaries, so a tap sweep is never interrupted. It sits between the host register interface and the coefficient RAMs, and drives the delay-line shift and MAC sequencing strobes.

## Interface
Parameters:
- `NUM_BANK`, 4, number of coefficient RAM banks (1..8)
- `BANK_AW`, 4, word-address width per bank
- `TAPS`, 16, words read per bank per sample (1..2**BANK_AW)
- `BSEL_W`, `$clog2(NUM_BANK)` (min 1), bank-select field width of the host address

Ports:
- `iClk_12M`  in  1  system clock
- `iRsn`  in  1  reset, asynchronous, active-low (one clock; reset is asynchronous and active-low)
- `iEnSample600k`  in  1  one-cycle sample strobe
- `iUpdateReq`  in  1  host requests coefficient-update mode (level)
- `oUpdateAck`  out  1  high while host mode is granted
- `iAddr`  in  BSEL_W+BANK_AW  host address, {bank, word}
- `iCsn`  in  1  host chip select, active-low
- `iWrn`  in  1  host write strobe, active-low
- `oCsn`  out  NUM_BANK  per-bank chip select, active-low
- `oWrn`  out  NUM_BANK  per-bank write enable, active-low
- `oAddr`  out  BANK_AW  shared bank word address
- `oEnDelay`  out  1  delay-line shift pulse
- `oRdValid`  out  1  RAM read data valid (all banks)
- `oTapIdx`  out  BANK_AW  tap index of the data qualified by oRdValid
- `oEnOut`  out  1  sample-complete pulse
- `oOverrun`  out  1  sample strobe lost during a sweep (pulse)
- `oSampleDrop`  out  1  sample strobe lost in host mode (pulse)
- `oHostErr`  out  1  host access refused or out of range (pulse)

## Operation
- States: IDLE, SHIFT, READ, DONE, HOST.
- IDLE with `iEnSample600k`=1 → SHIFT. The sample strobe wins over `iUpdateReq` in the same cycle.
- IDLE with `iUpdateReq`=1 and no strobe → HOST.
- SHIFT: `oEnDelay`=1 for one cycle, then → READ.
- READ: lasts `TAPS` cycles. All `oCsn`=0 and `oWrn`=all-1. `oAddr` counts 0..TAPS-1. At count TAPS-1 → DONE.
- DONE: `oEnOut`=1 for one cycle, then → IDLE. `iUpdateReq` raised during SHIFT/READ/DONE is serviced from IDLE.
- HOST: `oUpdateAck`=1. The host path passes through combinationally:
  - bank b = `iAddr[BANK_AW+:BSEL_W]`
  - `oCsn[b]`=`iCsn`, all other banks 1
  - `oWrn[b]`=`iWrn`
  - `oAddr`=`iAddr[BANK_AW-1:0]`
- HOST with `iUpdateReq`=0 → IDLE, provided `iCsn`=1. If `iCsn`=0, the state stays HOST until `iCsn` returns to 1.
- `iEnSample600k` in HOST: ignored, `oSampleDrop` pulses.
- `iEnSample600k` in SHIFT/READ/DONE: ignored, `oOverrun` pulses.
- `oHostErr` pulses for each cycle in which:
  - `iCsn`=0 outside HOST (no bank selected), or
  - `iCsn`=0 in HOST with bank ≥ `NUM_BANK` (no bank selected).
- Reset (any state, asynchronous) → IDLE with:
  - `oCsn`/`oWrn` all-1
  - `oAddr`, `oTapIdx` = 0
  - every strobe and flag = 0
  - `oUpdateAck` = 0
- A reset mid-sweep abandons the sweep; no `oEnOut` is issued.

## Timing
- Strobe sampled in IDLE at edge k:
  - `oEnDelay` high in cycle k+1
  - READ in cycles k+2..k+1+TAPS
  - `oRdValid` in k+3..k+2+TAPS, with `oTapIdx` = `oAddr` delayed one cycle (1-cycle synchronous RAM)
  - `oEnOut` in k+3+TAPS
  - IDLE from k+4+TAPS
- Frame cost is TAPS+4 cycles. At TAPS=16 this exactly meets the 20-cycle 12 MHz/600 kHz period.
- FSM-side outputs (`oCsn`, `oWrn`, `oAddr`, strobes) are registered. Only the HOST pass-through is combinational.
- `oUpdateAck`:
  - rises the cycle after the IDLE→HOST decision edge
  - falls the cycle after `iUpdateReq` deasserts with `iCsn`=1
- `oTapIdx` holds its last value when `oRdValid`=0.

## Structure
- Shared package (`fir_pkg`) holds:
  - state encoding constants
  - `NUM_BANK`/`BANK_AW`/`TAPS` defaults
  - the frame-budget constant (20 cycles)
- Natural sub-module: `coef_addr_decode`, a parametrised host bank decoder that outputs one-hot select plus out-of-range flag.
- The FSM, tap counter and valid pipeline stay in the top.

## Test plan
- Reset, then strobe every 20 cycles, TAPS=16:
  - `oEnDelay` at k+1
  - `oAddr` 0..15 with all `oCsn`=0
  - `oRdValid` 16 cycles with `oTapIdx` 0..15
  - `oEnOut` at k+19
  - no `oOverrun`
- Strobe at k and k+10: second strobe → `oOverrun`=1 at k+10; sweep completes unchanged.
- `iUpdateReq` raised mid-READ: `oUpdateAck` rises only after `oEnOut`. Host then writes `iAddr`=6'h25 → `oCsn[2]`=0, `oWrn[2]`=0, `oAddr`=4'h5, other banks 1.
- Host mode with strobe: `oSampleDrop`=1, no `oEnDelay`. `iUpdateReq` dropped while `iCsn`=0 → ack held until `iCsn`=1.
- `iCsn`=0 in IDLE → `oHostErr`=1, all `oCsn`=1. With NUM_BANK=3 in HOST, bank 3 → `oHostErr`=1.
- `iRsn` asserted at READ tap 7 → outputs at reset values immediately, no `oEnOut`. Next strobe starts a clean sweep from tap 0.

Source files
------------

// File: rtl/fir_pkg.sv
// fir_pkg: constants shared across the FIR datapath plus the coefficient
// access controller's state encoding and bank-select width helper.
package fir_pkg;

   localparam int DEF_NUM_BANK   = 4;
   localparam int DEF_BANK_AW    = 4;
   localparam int DEF_TAPS       = 16;

   // One 600 kHz sample period at 12 MHz, and the fixed sweep cost beyond TAPS
   localparam int FRAME_BUDGET   = 20;
   localparam int FRAME_OVERHEAD = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SHIFT = 3'd1,
      ST_READ  = 3'd2,
      ST_DONE  = 3'd3,
      ST_HOST  = 3'd4
   } coef_state_t;

   function automatic int bsel_width(input int numBank);
      return (numBank > 1) ? $clog2(numBank) : 1;
   endfunction

endpackage

// File: rtl/coef_addr_decode.sv
// coef_addr_decode: turns the host bank-select field into a one-hot bank
// select and flags bank numbers that do not exist.
module coef_addr_decode
   import fir_pkg::*;
#(
   parameter int NUM_BANK = DEF_NUM_BANK,
   parameter int BSEL_W   = bsel_width(DEF_NUM_BANK)
) (
   input  logic [BSEL_W-1:0]   iBank,
   output logic [NUM_BANK-1:0] oSel,
   output logic                oOutOfRange
);

   always_comb begin
      oSel = '0;
      for (int b = 0; b < NUM_BANK; b++) begin
         if (iBank == BSEL_W'(b)) begin
            oSel[b] = 1'b1;
         end
      end
      oOutOfRange = (32'(iBank) >= NUM_BANK);
   end

endmodule

// File: rtl/coef_access_ctrl.sv
// coef_access_ctrl: shares the coefficient RAM banks between host updates and
// the per-sample tap sweep, and sequences the delay-line shift and MAC strobes.
module coef_access_ctrl
   import fir_pkg::*;
#(
   parameter int NUM_BANK = DEF_NUM_BANK,
   parameter int BANK_AW  = DEF_BANK_AW,
   parameter int TAPS     = DEF_TAPS,
   parameter int BSEL_W   = bsel_width(NUM_BANK)
) (
   input  logic                      iClk_12M,
   input  logic                      iRsn,
   input  logic                      iEnSample600k,
   input  logic                      iUpdateReq,
   output logic                      oUpdateAck,
   input  logic [BSEL_W+BANK_AW-1:0] iAddr,
   input  logic                      iCsn,
   input  logic                      iWrn,
   output logic [NUM_BANK-1:0]       oCsn,
   output logic [NUM_BANK-1:0]       oWrn,
   output logic [BANK_AW-1:0]        oAddr,
   output logic                      oEnDelay,
   output logic                      oRdValid,
   output logic [BANK_AW-1:0]        oTapIdx,
   output logic                      oEnOut,
   output logic                      oOverrun,
   output logic                      oSampleDrop,
   output logic                      oHostErr
);

   localparam logic [BANK_AW-1:0] LAST_TAP = BANK_AW'(TAPS - 1);

   coef_state_t r_state, w_stateNext;

   logic [NUM_BANK-1:0] r_csn, w_csnNext;
   logic [BANK_AW-1:0]  r_addr, w_addrNext;
   logic [BANK_AW-1:0]  r_tapIdx, w_tapIdxNext;
   logic                r_enDelay, w_enDelayNext;
   logic                r_rdValid, w_rdValidNext;
   logic                r_enOut, w_enOutNext;
   logic                r_overrun, w_overrunNext;
   logic                r_sampleDrop, w_sampleDropNext;
   logic                r_hostErr, w_hostErrNext;
   logic                r_updateAck, w_updateAckNext;

   logic [NUM_BANK-1:0] w_bankSel;
   logic                w_bankOor;
   logic                w_hostMode;

   coef_addr_decode #(
      .NUM_BANK (NUM_BANK),
      .BSEL_W   (BSEL_W)
   ) u_decode (
      .iBank       (iAddr[BANK_AW +: BSEL_W]),
      .oSel        (w_bankSel),
      .oOutOfRange (w_bankOor)
   );

   assign w_hostMode = (r_state == ST_HOST);

   // The tap counter doubles as the RAM word address during READ.
   // DONE spans the last read-data cycle and then the oEnOut cycle.
   always_comb begin
      w_stateNext      = r_state;
      w_csnNext        = '1;
      w_addrNext       = r_addr;
      w_enDelayNext    = 1'b0;
      w_enOutNext      = 1'b0;
      w_overrunNext    = 1'b0;
      w_sampleDropNext = 1'b0;
      w_updateAckNext  = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (iEnSample600k) begin
               w_stateNext   = ST_SHIFT;
               w_enDelayNext = 1'b1;
            end else if (iUpdateReq) begin
               w_stateNext     = ST_HOST;
               w_updateAckNext = 1'b1;
            end
         end
         ST_SHIFT: begin
            w_overrunNext = iEnSample600k;
            w_stateNext   = ST_READ;
            w_csnNext     = '0;
            w_addrNext    = '0;
         end
         ST_READ: begin
            w_overrunNext = iEnSample600k;
            if (r_addr == LAST_TAP) begin
               w_stateNext = ST_DONE;
            end else begin
               w_csnNext  = '0;
               w_addrNext = r_addr + 1'b1;
            end
         end
         ST_DONE: begin
            w_overrunNext = iEnSample600k;
            if (r_rdValid) begin
               w_enOutNext = 1'b1;
            end else begin
               w_stateNext = ST_IDLE;
            end
         end
         ST_HOST: begin
            w_sampleDropNext = iEnSample600k;
            if (!iUpdateReq && iCsn) begin
               w_stateNext = ST_IDLE;
            end else begin
               w_updateAckNext = 1'b1;
            end
         end
         default: begin
            w_stateNext = ST_IDLE;
         end
      endcase
   end

   // Read data lags the address by one cycle through the synchronous RAM.
   always_comb begin
      w_rdValidNext = (r_state == ST_READ);
      w_tapIdxNext  = (r_state == ST_READ) ? r_addr : r_tapIdx;
      w_hostErrNext = ~iCsn & (~w_hostMode | w_bankOor);
   end

   always_ff @(posedge iClk_12M or negedge iRsn) begin
      if (!iRsn) begin
         r_state      <= ST_IDLE;
         r_csn        <= '1;
         r_addr       <= '0;
         r_tapIdx     <= '0;
         r_enDelay    <= 1'b0;
         r_rdValid    <= 1'b0;
         r_enOut      <= 1'b0;
         r_overrun    <= 1'b0;
         r_sampleDrop <= 1'b0;
         r_hostErr    <= 1'b0;
         r_updateAck  <= 1'b0;
      end else begin
         r_state      <= w_stateNext;
         r_csn        <= w_csnNext;
         r_addr       <= w_addrNext;
         r_tapIdx     <= w_tapIdxNext;
         r_enDelay    <= w_enDelayNext;
         r_rdValid    <= w_rdValidNext;
         r_enOut      <= w_enOutNext;
         r_overrun    <= w_overrunNext;
         r_sampleDrop <= w_sampleDropNext;
         r_hostErr    <= w_hostErrNext;
         r_updateAck  <= w_updateAckNext;
      end
   end

   // Host accesses bypass the registers so RAM writes see the bus directly.
   always_comb begin
      oCsn  = r_csn;
      oWrn  = '1;
      oAddr = r_addr;
      if (w_hostMode) begin
         oCsn  = ~(w_bankSel & {NUM_BANK{~iCsn}});
         oWrn  = ~(w_bankSel & {NUM_BANK{~iWrn}});
         oAddr = iAddr[BANK_AW-1:0];
      end
   end

   assign oUpdateAck  = r_updateAck;
   assign oEnDelay    = r_enDelay;
   assign oRdValid    = r_rdValid;
   assign oTapIdx     = r_tapIdx;
   assign oEnOut      = r_enOut;
   assign oOverrun    = r_overrun;
   assign oSampleDrop = r_sampleDrop;
   assign oHostErr    = r_hostErr;

endmodule

// File: tb/tb_coef_access_ctrl.sv
// tb_coef_access_ctrl: randomized and directed checks of the coefficient
// access controller against a sweep-timeline reference model.
module tb_coef_access_ctrl;

   localparam int NB   = 4;
   localparam int AW   = 4;
   localparam int TP   = 16;
   localparam int BW   = 2;
   localparam int NB3  = 3;
   localparam int TP3  = 4;
   localparam int BUNW = 7 + 2*NB + 2*AW;
   localparam logic [BUNW-1:0] RESET_BUNDLE = {7'b0, 4'hF, 4'hF, 4'h0, 4'h0};

   logic clk = 1'b0;
   logic rsn = 1'b1;

   logic          strobe = 1'b0, req = 1'b0, csn = 1'b1, wrn = 1'b1;
   logic [BW+AW-1:0] addr = '0;
   logic          ack, enDelay, rdValid, enOut, overrun, sampleDrop, hostErr;
   logic [NB-1:0] oCsnV, oWrnV;
   logic [AW-1:0] oAddrV, tapIdx;

   logic          strobe3 = 1'b0, req3 = 1'b0, csn3 = 1'b1, wrn3 = 1'b1;
   logic [BW+AW-1:0] addr3 = '0;
   logic          ack3, enDelay3, rdValid3, enOut3, overrun3, sampleDrop3, hostErr3;
   logic [NB3-1:0] oCsn3, oWrn3;
   logic [AW-1:0] oAddr3, tapIdx3;

   int checks = 0;
   int errors = 0;

   // reference model: a sweep is described by the edge it was accepted on
   int            edgeCnt = 0;
   int            kStart  = 0;
   bit            sweepOn = 1'b0;
   bit            mHost   = 1'b0;
   bit            eReading = 1'b0;
   logic          eEnDelay = 1'b0, eRdValid = 1'b0, eEnOut = 1'b0;
   logic          eOverrun = 1'b0, eDrop = 1'b0, eHostErr = 1'b0;
   logic [AW-1:0] mAddr = '0, mTapIdx = '0;

   always #5 clk = ~clk;

   coef_access_ctrl #(.NUM_BANK(NB), .BANK_AW(AW), .TAPS(TP)) dut (
      .iClk_12M(clk), .iRsn(rsn), .iEnSample600k(strobe), .iUpdateReq(req),
      .oUpdateAck(ack), .iAddr(addr), .iCsn(csn), .iWrn(wrn),
      .oCsn(oCsnV), .oWrn(oWrnV), .oAddr(oAddrV), .oEnDelay(enDelay),
      .oRdValid(rdValid), .oTapIdx(tapIdx), .oEnOut(enOut), .oOverrun(overrun),
      .oSampleDrop(sampleDrop), .oHostErr(hostErr)
   );

   coef_access_ctrl #(.NUM_BANK(NB3), .BANK_AW(AW), .TAPS(TP3)) dut3 (
      .iClk_12M(clk), .iRsn(rsn), .iEnSample600k(strobe3), .iUpdateReq(req3),
      .oUpdateAck(ack3), .iAddr(addr3), .iCsn(csn3), .iWrn(wrn3),
      .oCsn(oCsn3), .oWrn(oWrn3), .oAddr(oAddr3), .oEnDelay(enDelay3),
      .oRdValid(rdValid3), .oTapIdx(tapIdx3), .oEnOut(enOut3), .oOverrun(overrun3),
      .oSampleDrop(sampleDrop3), .oHostErr(hostErr3)
   );

   function automatic logic [BUNW-1:0] obsBundle();
      return {enDelay, rdValid, enOut, overrun, sampleDrop, hostErr, ack,
              oCsnV, oWrnV, oAddrV, tapIdx};
   endfunction

   // expected outputs for the current cycle, including host pass-through of the live bus
   function automatic logic [BUNW-1:0] expBundle();
      logic [NB-1:0] c;
      logic [NB-1:0] w;
      logic [AW-1:0] a;
      int bank;
      bank = int'(addr[AW +: BW]);
      c = '1;
      w = '1;
      a = mAddr;
      if (mHost) begin
         for (int b = 0; b < NB; b++) begin
            if (b == bank) begin
               c[b] = csn;
               w[b] = wrn;
            end
         end
         a = addr[AW-1:0];
      end else if (eReading) begin
         c = '0;
      end
      return {eEnDelay, eRdValid, eEnOut, eOverrun, eDrop, eHostErr, mHost, c, w, a, mTapIdx};
   endfunction

   task automatic modelReset();
      sweepOn  = 1'b0;
      mHost    = 1'b0;
      eReading = 1'b0;
      eEnDelay = 1'b0; eRdValid = 1'b0; eEnOut = 1'b0;
      eOverrun = 1'b0; eDrop = 1'b0; eHostErr = 1'b0;
      mAddr    = '0;
      mTapIdx  = '0;
   endtask

   // advance one clock; the model consumes the inputs present at the edge
   task automatic tick();
      int  rel;
      bit  busy;
      bit  hostBefore;
      @(posedge clk);
      edgeCnt++;
      rel        = edgeCnt - kStart;
      busy       = sweepOn && rel >= 1 && rel <= TP + 3;
      hostBefore = mHost;
      eOverrun   = busy && strobe;
      eDrop      = hostBefore && strobe;
      eHostErr   = !csn && (!hostBefore || int'(addr[AW +: BW]) >= NB);
      eEnDelay   = 1'b0;
      if (!busy && !hostBefore) begin
         if (strobe) begin
            kStart   = edgeCnt;
            sweepOn  = 1'b1;
            eEnDelay = 1'b1;
         end else if (req) begin
            mHost = 1'b1;
         end
      end else if (hostBefore && !req && csn) begin
         mHost = 1'b0;
      end
      rel      = edgeCnt - kStart;
      eReading = sweepOn && rel >= 1 && rel <= TP;
      if (eReading) mAddr = AW'(rel - 1);
      eRdValid = sweepOn && rel >= 2 && rel <= TP + 1;
      if (eRdValid) mTapIdx = AW'(rel - 2);
      eEnOut   = sweepOn && rel == TP + 2;
      #1;
   endtask

   task automatic test_reset();
      #2 rsn = 1'b0;
      #1;
      modelReset();
      checks++;
      if (obsBundle() !== RESET_BUNDLE) begin
         errors++;
         $display("[TB] FAIL reset_state got=%h exp=%h", obsBundle(), RESET_BUNDLE);
      end
      checks++;
      if ({ack3, oCsn3, oWrn3} !== {1'b0, 3'b111, 3'b111}) begin
         errors++;
         $display("[TB] FAIL reset_state3 got=%b exp=%b", {ack3, oCsn3, oWrn3}, 7'b0111111);
      end
      @(posedge clk);
      #1 rsn = 1'b1;
   endtask

   task automatic test_sweep();
      int enOutCnt = 0;
      int validCnt = 0;
      int overCnt  = 0;
      for (int f = 0; f < 3; f++) begin
         for (int c = 0; c < TP + 4; c++) begin
            strobe = (c == 0);
            tick();
            checks++;
            if (obsBundle() !== expBundle()) begin
               errors++;
               $display("[TB] FAIL sweep edge=%0d got=%h exp=%h", edgeCnt, obsBundle(), expBundle());
            end
            if (enOut) enOutCnt++;
            if (rdValid) validCnt++;
            if (overrun) overCnt++;
         end
      end
      strobe = 1'b0;
      checks++;
      if (enOutCnt != 3 || validCnt != 3*TP || overCnt != 0) begin
         errors++;
         $display("[TB] FAIL sweep_counts got enOut=%0d valid=%0d overrun=%0d exp 3 %0d 0",
                  enOutCnt, validCnt, overCnt, 3*TP);
      end
   endtask

   task automatic test_overrun();
      for (int c = 0; c < TP + 6; c++) begin
         strobe = (c == 0 || c == 10);
         tick();
         checks++;
         if (obsBundle() !== expBundle()) begin
            errors++;
            $display("[TB] FAIL overrun_seq edge=%0d got=%h exp=%h", edgeCnt, obsBundle(), expBundle());
         end
         if (c == 10) begin
            checks++;
            if (overrun !== 1'b1) begin
               errors++;
               $display("[TB] FAIL overrun_pulse got=%b exp=1", overrun);
            end
         end
      end
      strobe = 1'b0;
   endtask

   task automatic test_update_mid_read();
      strobe = 1'b1;
      tick();
      strobe = 1'b0;
      for (int c = 0; c < 5; c++) tick();
      req = 1'b1;
      for (int c = 0; c < TP; c++) begin
         tick();
         checks++;
         if (oUpdateAckExpected() !== ack) begin
            errors++;
            $display("[TB] FAIL ack_after_sweep rel=%0d got=%b exp=%b", edgeCnt - kStart, ack, oUpdateAckExpected());
         end
         checks++;
         if (obsBundle() !== expBundle()) begin
            errors++;
            $display("[TB] FAIL update_seq edge=%0d got=%h exp=%h", edgeCnt, obsBundle(), expBundle());
         end
      end
      addr = 6'h25;
      csn  = 1'b0;
      wrn  = 1'b0;
      #1;
      checks++;
      if ({oCsnV, oWrnV, oAddrV} !== {4'b1011, 4'b1011, 4'h5}) begin
         errors++;
         $display("[TB] FAIL host_write got csn=%b wrn=%b addr=%h exp 1011 1011 5", oCsnV, oWrnV, oAddrV);
      end
      tick();
      csn = 1'b1;
      wrn = 1'b1;
   endtask

   function automatic logic oUpdateAckExpected();
      return (edgeCnt - kStart) >= TP + 4;
   endfunction

   task automatic test_host_strobe();
      strobe = 1'b1;
      tick();
      strobe = 1'b0;
      checks++;
      if ({sampleDrop, enDelay, ack} !== 3'b101) begin
         errors++;
         $display("[TB] FAIL host_strobe got drop=%b enDelay=%b ack=%b exp 1 0 1", sampleDrop, enDelay, ack);
      end
      csn = 1'b0;
      req = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if (ack !== 1'b1 || obsBundle() !== expBundle()) begin
            errors++;
            $display("[TB] FAIL ack_hold got=%h exp=%h", obsBundle(), expBundle());
         end
      end
      csn = 1'b1;
      tick();
      checks++;
      if (ack !== 1'b0) begin
         errors++;
         $display("[TB] FAIL ack_release got=%b exp=0", ack);
      end
   endtask

   task automatic test_host_err();
      csn  = 1'b0;
      addr = 6'(($urandom % 64));
      #1;
      checks++;
      if (oCsnV !== 4'b1111) begin
         errors++;
         $display("[TB] FAIL idle_csn got=%b exp=1111", oCsnV);
      end
      tick();
      checks++;
      if (hostErr !== 1'b1) begin
         errors++;
         $display("[TB] FAIL idle_hosterr got=%b exp=1", hostErr);
      end
      csn = 1'b1;
      tick();
      checks++;
      if (hostErr !== 1'b0) begin
         errors++;
         $display("[TB] FAIL hosterr_clear got=%b exp=0", hostErr);
      end
      req3 = 1'b1;
      tick();
      tick();
      checks++;
      if (ack3 !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ack3 got=%b exp=1", ack3);
      end
      csn3  = 1'b0;
      addr3 = {2'd3, 4'h9};
      #1;
      checks++;
      if (oCsn3 !== 3'b111) begin
         errors++;
         $display("[TB] FAIL oor_csn got=%b exp=111", oCsn3);
      end
      tick();
      checks++;
      if (hostErr3 !== 1'b1) begin
         errors++;
         $display("[TB] FAIL oor_hosterr got=%b exp=1", hostErr3);
      end
      addr3 = {2'd2, 4'h9};
      #1;
      checks++;
      if ({oCsn3, oAddr3} !== {3'b011, 4'h9}) begin
         errors++;
         $display("[TB] FAIL bank2_pass got csn=%b addr=%h exp 011 9", oCsn3, oAddr3);
      end
      tick();
      checks++;
      if (hostErr3 !== 1'b0) begin
         errors++;
         $display("[TB] FAIL bank2_hosterr got=%b exp=0", hostErr3);
      end
      csn3 = 1'b1;
      req3 = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_sweep();
      int enOutCnt = 0;
      strobe = 1'b1;
      tick();
      strobe = 1'b0;
      for (int c = 0; c < 8; c++) tick();
      checks++;
      if (oAddrV !== 4'd7 || oCsnV !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL tap7 got addr=%0d csn=%b exp 7 0000", oAddrV, oCsnV);
      end
      #3 rsn = 1'b0;
      #1;
      modelReset();
      checks++;
      if (obsBundle() !== RESET_BUNDLE) begin
         errors++;
         $display("[TB] FAIL async_reset got=%h exp=%h", obsBundle(), RESET_BUNDLE);
      end
      @(posedge clk);
      #1 rsn = 1'b1;
      for (int c = 0; c < TP + 6; c++) begin
         tick();
         if (enOut) enOutCnt++;
      end
      checks++;
      if (enOutCnt != 0) begin
         errors++;
         $display("[TB] FAIL no_enout_after_reset got=%0d exp=0", enOutCnt);
      end
      for (int c = 0; c < TP + 4; c++) begin
         strobe = (c == 0);
         tick();
         checks++;
         if (obsBundle() !== expBundle()) begin
            errors++;
            $display("[TB] FAIL clean_sweep edge=%0d got=%h exp=%h", edgeCnt, obsBundle(), expBundle());
         end
         if (c == 1) begin
            checks++;
            if (oAddrV !== 4'd0 || oCsnV !== 4'b0000) begin
               errors++;
               $display("[TB] FAIL clean_tap0 got addr=%0d csn=%b exp 0 0000", oAddrV, oCsnV);
            end
         end
      end
      strobe = 1'b0;
   endtask

   task automatic test_random();
      for (int c = 0; c < 800; c++) begin
         strobe = ($urandom % 6) == 0;
         if (($urandom % 20) == 0) req = ~req;
         csn  = ($urandom % 4) != 0;
         wrn  = $urandom % 2;
         addr = 6'($urandom % 64);
         tick();
         checks++;
         if (obsBundle() !== expBundle()) begin
            errors++;
            $display("[TB] FAIL random edge=%0d got=%h exp=%h", edgeCnt, obsBundle(), expBundle());
         end
      end
      strobe = 1'b0;
      req    = 1'b0;
      csn    = 1'b1;
      for (int c = 0; c < TP + 6; c++) tick();
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      test_reset();
      test_sweep();
      test_overrun();
      test_update_mid_read();
      test_host_strobe();
      test_host_err();
      test_reset_mid_sweep();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
